// File: rtl/wb_dma_mem_arbiter_if.sv
// Bundle of the four DMA requester buses plus the single Wishbone master port to EXMEM.
// master = arbiter view; slave = environment view (requesters and EXMEM slave).
interface wb_dma_mem_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_cyc;
  logic [N_REQ-1:0]    req_stb;
  logic [N_REQ-1:0]    req_we;
  logic [4*N_REQ-1:0]  req_sel;
  logic [32*N_REQ-1:0] req_adr;
  logic [32*N_REQ-1:0] req_dat;
  logic [N_REQ-1:0]    req_ack;
  logic [N_REQ-1:0]    req_err;
  logic [31:0]         req_dat_o;
  logic                m_cyc;
  logic                m_stb;
  logic                m_we;
  logic [3:0]          m_sel;
  logic [31:0]         m_adr;
  logic [31:0]         m_dat;
  logic                m_ack;
  logic [31:0]         m_dat_i;
  logic [N_REQ-1:0]    grant;
  logic                busy;

  modport master (
    input  req_cyc, req_stb, req_we, req_sel, req_adr, req_dat, m_ack, m_dat_i,
    output req_ack, req_err, req_dat_o, m_cyc, m_stb, m_we, m_sel, m_adr, m_dat,
    output grant, busy
  );

  modport slave (
    output req_cyc, req_stb, req_we, req_sel, req_adr, req_dat, m_ack, m_dat_i,
    input  req_ack, req_err, req_dat_o, m_cyc, m_stb, m_we, m_sel, m_adr, m_dat,
    input  grant, busy
  );
endinterface

// File: rtl/wb_dma_mem_arbiter.sv
// Round-robin (optional CPU-priority) arbiter sharing the EXMEM Wishbone port between DMA engines.
// One cycle request-to-grant, then zero-cycle passthrough; losers simply see no ack until granted.
module wb_dma_mem_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64,
  parameter int CPU_PRIO  = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_dma_mem_arbiter_if.master  bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt, gidx, gidx_nxt, win_idx, cand;
  logic [N_REQ-1:0] grant_q, grant_nxt, err_q, err_nxt, reqs;
  logic [7:0]       burst_cnt, burst_nxt, burst_inc;
  logic [9:0]       tmo_cnt, tmo_nxt;
  logic             found, beat, others, tmo_hit, force_rel;
  logic             mcyc, mstb, mwe;
  logic [3:0]       msel;
  logic [31:0]      madr, mdat;

  assign reqs = bus.req_cyc & bus.req_stb;

  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!found && reqs[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
    if (CPU_PRIO != 0 && reqs[0]) win_idx = '0;
  end

  // grant_q is one-hot or zero, so at most one requester drives the master port
  always_comb begin
    mcyc = 1'b0;
    mstb = 1'b0;
    mwe  = 1'b0;
    msel = '0;
    madr = '0;
    mdat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        mcyc = bus.req_cyc[i];
        mstb = bus.req_stb[i];
        mwe  = bus.req_we[i];
        msel = bus.req_sel[4*i +: 4];
        madr = bus.req_adr[32*i +: 32];
        mdat = bus.req_dat[32*i +: 32];
      end
    end
  end

  assign beat      = mstb & bus.m_ack;
  assign others    = |(reqs & ~grant_q);
  assign tmo_hit   = mstb & ~bus.m_ack & (tmo_cnt == 10'(TIMEOUT - 1));
  assign force_rel = beat & others & (({1'b0, burst_cnt} + 9'd1) >= 9'(MAX_BURST));
  assign burst_inc = (burst_cnt == 8'(MAX_BURST)) ? burst_cnt : burst_cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    grant_nxt = grant_q;
    err_nxt   = '0;
    burst_nxt = burst_cnt;
    tmo_nxt   = tmo_cnt;
    case (state)
      IDLE: begin
        if (|reqs) begin
          grant_nxt = N_REQ'(1) << win_idx;
          gidx_nxt  = win_idx;
          burst_nxt = '0;
          tmo_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (beat) begin
          burst_nxt = burst_inc;
          tmo_nxt   = '0;
        end else if (mstb) begin
          tmo_nxt = tmo_cnt + 10'd1;
        end
        if (!mcyc || force_rel || tmo_hit) begin
          state_nxt = GAP;
          grant_nxt = '0;
          ptr_nxt   = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
          if (tmo_hit) err_nxt = grant_q;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      ptr       <= PW'(1);
      gidx      <= '0;
      grant_q   <= '0;
      err_q     <= '0;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gidx      <= gidx_nxt;
      grant_q   <= grant_nxt;
      err_q     <= err_nxt;
      burst_cnt <= burst_nxt;
      tmo_cnt   <= tmo_nxt;
    end
  end

  assign bus.m_cyc     = mcyc;
  assign bus.m_stb     = mstb;
  assign bus.m_we      = mwe;
  assign bus.m_sel     = msel;
  assign bus.m_adr     = madr;
  assign bus.m_dat     = mdat;
  assign bus.req_ack   = grant_q & {N_REQ{beat}};
  assign bus.req_err   = err_q;
  assign bus.req_dat_o = bus.m_dat_i;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state == GRANT);
endmodule
